typec_rxf: RTL and testbench
============================

TYPEC_RXF -- requirements
Module: typec_rxf

Interface
REQ-001 Parameter SYNC_DATA, default 8'h0F, sync byte marking start of payload.
REQ-002 Parameter HUNT_MAX, default 16, maximum fire-high nibbles allowed before sync is found.
REQ-003 Parameter LEN_W, default 8, width of the payload byte counter.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 din  input  4  received nibble, sampled only when fire is high.
REQ-007 fire  input  1  nibble-valid; high for the whole frame (preamble, sync, payload, 2 guard nibbles).
REQ-008 dout  output  8  reassembled payload byte.
REQ-009 dval  output  1  one-cycle strobe, dout valid.
REQ-010 sof  output  1  one-cycle strobe coincident with dval of the first payload byte.
REQ-011 eof  output  1  one-cycle strobe, frame ended.
REQ-012 err  output  1  one-cycle strobe, framing error (coincides with eof when raised at frame end).
REQ-013 len  output  LEN_W  payload byte count of the last frame, updated when eof pulses.

Function
REQ-014 Frame nibble order: preamble, sync byte (high nibble first), payload bytes (high nibble first), two guard nibbles 4'h0, then fire low.
REQ-015 States: IDLE, HUNT, HI, LO, DONE.
REQ-016 IDLE -> HUNT on the first cycle with fire high; otherwise stay in IDLE.
REQ-017 HUNT: each cycle, shift din into a 2-nibble window; when {previous, current} == SYNC_DATA with both nibbles sampled while fire is high, go to HI.
REQ-018 HUNT: if fire falls before sync is found, go to DONE with err set and len = 0.
REQ-019 HUNT: if HUNT_MAX nibbles pass without sync, go to DONE with err set and len = 0.
REQ-020 HI: with fire high, latch din as byte[7:4] and go to LO.
REQ-021 HI: with fire low, the frame ended on a byte boundary; go to DONE.
REQ-022 LO: with fire high, complete the byte with din as byte[3:0] and go to HI.
REQ-023 LO: with fire low (odd nibble count), go to DONE with err set.
REQ-024 One-byte hold register: a completed byte is emitted only when the next byte completes.
REQ-025 On fire low, the held byte is the guard byte and is discarded.
REQ-026 dout/dval are registered: dval rises in the cycle after the low nibble of byte n+1 is sampled, carrying byte n.
REQ-027 Minimum frame is sync + guard; it yields no dval and len = 0.
REQ-028 len counts emitted bytes and saturates at 2^LEN_W-1; saturation does not raise err.
REQ-029 DONE: pulse eof (and err if flagged), load len, return to IDLE; DONE lasts exactly one cycle.
REQ-030 fire already high again in DONE: the new frame starts from IDLE on the next cycle, so no nibble sampled during DONE belongs to it.
REQ-031 Outputs are never driven from combinational paths on din or fire.

Reset
REQ-032 When rst is high at a clock edge: state = IDLE; dout = 8'h00; dval, sof, eof, err = 0; len = 0; hold register, nibble window and counters cleared.
REQ-033 Reset mid-frame abandons the frame silently: no eof, err or dval.
REQ-034 The block then waits for fire low, then high, before hunting again.

Structure
REQ-035 SYNC_DATA, the guard nibble value 4'h0 and the state encodings live in the shared typec package, used by both transmit and receive sides.
REQ-036 The block is a single module with no sub-modules.

Verification
REQ-037 Preamble 4'h3,4'h3, sync 0,F, payload A5 3C, guard 0,0, fire low -> dval twice (A5 with sof, then 3C); eof with len = 2; err = 0.
REQ-038 Sync and guard only -> no dval; eof with len = 0; err = 0.
REQ-039 Sync, payload nibbles A,5,C, fire low (odd count) -> dval A5 with sof; eof + err; len = 1.
REQ-040 20 preamble nibbles 4'h1 with no sync (HUNT_MAX = 16) -> eof + err after the 16th nibble; no dval.
REQ-041 rst pulsed after the first payload byte, then a clean frame with payload 77 -> no output from the aborted frame; second frame gives dval 77 with sof and eof with len = 1.
REQ-042 Two back-to-back frames with fire low for 1 cycle between them (payloads 11 and 22) -> both decoded; two eof pulses; each len = 1.

Source files
------------

// File: rtl/typec_pkg.sv
// Shared Type-C framing definitions used by both the transmit and receive sides.
package typec_pkg;

    // Byte that marks the end of the preamble and the start of the payload.
    localparam logic [7:0] SYNC_BYTE    = 8'h0F;

    // Value of each of the two trailing guard nibbles.
    localparam logic [3:0] GUARD_NIBBLE = 4'h0;

    // Receive framer states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HUNT = 3'd1,
        ST_HI   = 3'd2,
        ST_LO   = 3'd3,
        ST_DONE = 3'd4
    } rx_state_e;

endpackage

// File: rtl/typec_rxf.sv
// Type-C nibble-stream receive framer: hunts for the sync byte, reassembles
// payload bytes through a one-byte hold register (so the trailing guard byte
// is dropped), and reports frame end, framing errors and the payload length.
module typec_rxf
    import typec_pkg::*;
#(
    parameter logic [7:0] SYNC_DATA = SYNC_BYTE,
    parameter int         HUNT_MAX  = 16,
    parameter int         LEN_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       din,
    input  logic             fire,
    output logic [7:0]       dout,
    output logic             dval,
    output logic             sof,
    output logic             eof,
    output logic             err,
    output logic [LEN_W-1:0] len
);

    localparam int               HC_W      = $clog2(HUNT_MAX + 1);
    localparam logic [HC_W-1:0]  HUNT_LAST = HC_W'(HUNT_MAX - 1);
    localparam logic [LEN_W-1:0] LEN_MAX   = '1;

    rx_state_e        state_q,    state_d;
    logic [3:0]       win_q,      win_d;       // previous nibble of the sync window
    logic [HC_W-1:0]  hunt_cnt_q, hunt_cnt_d;  // nibbles seen while hunting
    logic [3:0]       hi_q,       hi_d;        // high nibble of the byte in progress
    logic [7:0]       hold_q,     hold_d;      // last completed byte, not yet emitted
    logic             hold_vld_q, hold_vld_d;
    logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;  // bytes emitted in this frame
    logic             armed_q,    armed_d;     // fire has been seen low since the last frame start
    logic [7:0]       dout_q,     dout_d;
    logic             dval_q,     dval_d;
    logic             sof_q,      sof_d;
    logic             eof_q,      eof_d;
    logic             err_q,      err_d;
    logic [LEN_W-1:0] len_q,      len_d;

    logic             emit;
    logic [LEN_W-1:0] byte_cnt_inc;

    // Next-state, hold-register and output-strobe logic for the framer.
    always_comb begin
        // NOTE: every variable gets a default here so no path leaves one unassigned and infers a latch.
        state_d      = state_q;
        win_d        = win_q;
        hunt_cnt_d   = hunt_cnt_q;
        hi_d         = hi_q;
        hold_d       = hold_q;
        hold_vld_d   = hold_vld_q;
        byte_cnt_d   = byte_cnt_q;
        armed_d      = armed_q | ~fire;
        dout_d       = dout_q;
        dval_d       = 1'b0;
        sof_d        = 1'b0;
        eof_d        = 1'b0;
        err_d        = 1'b0;
        len_d        = len_q;
        emit         = 1'b0;
        byte_cnt_inc = (byte_cnt_q == LEN_MAX) ? byte_cnt_q : byte_cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                // A frame may only start after fire was low, so the tail of an
                // abandoned or timed-out frame is never mistaken for a new one.
                if (fire && armed_q) begin
                    state_d    = ST_HUNT;
                    win_d      = din;
                    hunt_cnt_d = HC_W'(1);
                    armed_d    = 1'b0;
                    hold_vld_d = 1'b0;
                    byte_cnt_d = '0;
                end
            end
            ST_HUNT: begin
                if (!fire) begin
                    state_d = ST_DONE;
                    eof_d   = 1'b1;
                    err_d   = 1'b1;
                    len_d   = '0;
                end else if ({win_q, din} == SYNC_DATA) begin
                    state_d = ST_HI;
                end else if (hunt_cnt_q >= HUNT_LAST) begin
                    state_d = ST_DONE;
                    eof_d   = 1'b1;
                    err_d   = 1'b1;
                    len_d   = '0;
                end else begin
                    win_d      = din;
                    hunt_cnt_d = hunt_cnt_q + 1'b1;
                end
            end
            ST_HI: begin
                if (fire) begin
                    hi_d    = din;
                    state_d = ST_LO;
                end else begin
                    // Clean end on a byte boundary: the held byte is the guard byte.
                    state_d = ST_DONE;
                    eof_d   = 1'b1;
                    len_d   = byte_cnt_q;
                end
            end
            ST_LO: begin
                if (fire) begin
                    emit       = hold_vld_q;
                    hold_d     = {hi_q, din};
                    hold_vld_d = 1'b1;
                    state_d    = ST_HI;
                end else begin
                    // Odd nibble count: no guard arrived, so the held byte is real payload.
                    emit    = hold_vld_q;
                    state_d = ST_DONE;
                    eof_d   = 1'b1;
                    err_d   = 1'b1;
                    len_d   = hold_vld_q ? byte_cnt_inc : byte_cnt_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (emit) begin
            dout_d     = hold_q;
            dval_d     = 1'b1;
            sof_d      = (byte_cnt_q == '0);
            byte_cnt_d = byte_cnt_inc;
        end
    end

    // State and registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: the window, hold register and counters are reset too, so a frame aborted by rst leaves no residue.
        if (rst) begin
            state_q    <= ST_IDLE;
            win_q      <= '0;
            hunt_cnt_q <= '0;
            hi_q       <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            byte_cnt_q <= '0;
            armed_q    <= 1'b0;
            dout_q     <= '0;
            dval_q     <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            err_q      <= 1'b0;
            len_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q    <= state_d;
            win_q      <= win_d;
            hunt_cnt_q <= hunt_cnt_d;
            hi_q       <= hi_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            byte_cnt_q <= byte_cnt_d;
            armed_q    <= armed_d;
            dout_q     <= dout_d;
            dval_q     <= dval_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
            err_q      <= err_d;
            len_q      <= len_d;
        end
    end

    assign dout = dout_q;
    assign dval = dval_q;
    assign sof  = sof_q;
    assign eof  = eof_q;
    assign err  = err_q;
    assign len  = len_q;

endmodule

// File: tb/tb_typec_rxf.sv
// Scoreboard bench for typec_rxf: stimulus pushes expected events into a
// queue, an independent monitor pops and compares on every dval / eof.
module tb_typec_rxf;
    import typec_pkg::*;

    localparam int HMAX = 16;
    localparam int LW   = 4;              // small width so length saturation is reachable
    localparam int LMAX = (1 << LW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    din;
    logic          fire;
    logic [7:0]    dout;
    logic          dval, sof, eof, err;
    logic [LW-1:0] len;

    typedef struct {
        bit         is_eof;
        logic [7:0] data;
        bit         first;
        bit         bad;
        int         count;
    } ev_t;

    ev_t        exp_q[$];
    logic [3:0] frm[$];
    int         n_checks = 0;
    int         n_errors = 0;
    bit         prev_end_low = 1'b0;
    bit         mon_en = 1'b0;

    typec_rxf #(.SYNC_DATA(SYNC_BYTE), .HUNT_MAX(HMAX), .LEN_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .din (din),
        .fire(fire),
        .dout(dout),
        .dval(dval),
        .sof (sof),
        .eof (eof),
        .err (err),
        .len (len)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got an output event, expected none (t=%0t)", name, $time);
    endtask

    task automatic push_byte(input logic [7:0] d, input bit first);
        ev_t e;
        e.is_eof = 1'b0; e.data = d; e.first = first; e.bad = 1'b0; e.count = 0;
        exp_q.push_back(e);
    endtask

    task automatic push_eof(input bit bad, input int count);
        ev_t e;
        e.is_eof = 1'b1; e.data = 8'h00; e.first = 1'b0; e.bad = bad; e.count = count;
        exp_q.push_back(e);
    endtask

    // One clock of stimulus; inputs change just after the rising edge.
    task automatic cyc(input logic f, input logic [3:0] d);
        fire = f;
        din  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input int gap);
        repeat (gap) cyc(1'b0, 4'h0);
        foreach (frm[i]) cyc(1'b1, frm[i]);
    endtask

    // Reference model: from the frame's nibble list, work out which payload
    // bytes appear, whether the frame is erroneous and its reported length.
    task automatic model_frame(input int gap);
        logic [3:0] eff[$];
        int  sync_at;
        bit  timeout;
        int  np, nb, emitted;
        bit  odd;
        eff     = frm;
        sync_at = -1;
        timeout = 1'b0;
        // With a single idle cycle after a fire-low ending, the first nibble
        // lands in the one-cycle end-of-frame state and is not part of the frame.
        if (gap == 1 && prev_end_low) void'(eff.pop_front());
        for (int i = 0; i < eff.size(); i++) begin
            if (i >= 1 && {eff[i-1], eff[i]} == SYNC_BYTE) begin
                sync_at = i;
                break;
            end
            if (i + 1 == HMAX) begin
                timeout = 1'b1;
                break;
            end
        end
        if (sync_at < 0) begin
            push_eof(1'b1, 0);
            prev_end_low = !timeout;
            return;
        end
        np      = eff.size() - sync_at - 1;
        nb      = np / 2;
        odd     = (np % 2) != 0;
        emitted = odd ? nb : ((nb > 0) ? nb - 1 : 0);
        for (int b = 0; b < emitted; b++)
            push_byte({eff[sync_at + 1 + 2*b], eff[sync_at + 2 + 2*b]}, b == 0);
        push_eof(odd, (emitted > LMAX) ? LMAX : emitted);
        prev_end_low = 1'b1;
    endtask

    // Monitor: compares every output event with the head of the scoreboard.
    always @(negedge clk) begin
        ev_t e;
        if (mon_en && !rst) begin
            if (dval) begin
                if (exp_q.size() == 0) unexpected("unexpected_dval");
                else begin
                    e = exp_q.pop_front();
                    check("event_is_byte", 0, int'(e.is_eof));
                    check("dout", int'(dout), int'(e.data));
                    check("sof", int'(sof), int'(e.first));
                end
            end else if (sof) begin
                unexpected("sof_without_dval");
            end
            if (eof) begin
                if (exp_q.size() == 0) unexpected("unexpected_eof");
                else begin
                    e = exp_q.pop_front();
                    check("event_is_eof", 1, int'(e.is_eof));
                    check("err", int'(err), int'(e.bad));
                    check("len", int'(len), e.count);
                end
            end else if (err) begin
                unexpected("err_without_eof");
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gap, npre, npay;
        rst  = 1'b1;
        fire = 1'b0;
        din  = 4'h0;
        cyc(1'b0, 4'h0);
        cyc(1'b0, 4'h0);
        check("reset_dout", int'(dout), 0);
        check("reset_dval", int'(dval), 0);
        check("reset_sof",  int'(sof),  0);
        check("reset_eof",  int'(eof),  0);
        check("reset_err",  int'(err),  0);
        check("reset_len",  int'(len),  0);
        rst = 1'b0;
        cyc(1'b0, 4'h0);
        mon_en = 1'b1;

        // Preamble, sync, payload A5 3C, guard.
        frm = '{4'h3, 4'h3, 4'h0, 4'hF, 4'hA, 4'h5, 4'h3, 4'hC, 4'h0, 4'h0};
        push_byte(8'hA5, 1'b1); push_byte(8'h3C, 1'b0); push_eof(1'b0, 2);
        drive_frame(3);

        // Sync and guard only.
        frm = '{4'h0, 4'hF, 4'h0, 4'h0};
        push_eof(1'b0, 0);
        drive_frame(3);

        // Odd nibble count after the payload.
        frm = '{4'h0, 4'hF, 4'hA, 4'h5, 4'hC};
        push_byte(8'hA5, 1'b1); push_eof(1'b1, 1);
        drive_frame(3);

        // No sync within the hunt limit.
        frm = {};
        repeat (20) frm.push_back(4'h1);
        push_eof(1'b1, 0);
        drive_frame(3);

        // Reset mid-frame, then a clean frame.
        frm = '{4'h3, 4'h3, 4'h0, 4'hF, 4'h1, 4'h2};
        drive_frame(3);
        rst = 1'b1;
        cyc(1'b1, 4'h3);
        rst = 1'b0;
        cyc(1'b1, 4'h4);
        cyc(1'b1, 4'h0);
        cyc(1'b1, 4'h0);
        frm = '{4'h3, 4'h3, 4'h0, 4'hF, 4'h7, 4'h7, 4'h0, 4'h0};
        push_byte(8'h77, 1'b1); push_eof(1'b0, 1);
        drive_frame(2);

        // Back-to-back frames with a single idle cycle between them.
        frm = '{4'h3, 4'h3, 4'h0, 4'hF, 4'h1, 4'h1, 4'h0, 4'h0};
        push_byte(8'h11, 1'b1); push_eof(1'b0, 1);
        drive_frame(3);
        frm = '{4'h3, 4'h3, 4'h0, 4'hF, 4'h2, 4'h2, 4'h0, 4'h0};
        push_byte(8'h22, 1'b1); push_eof(1'b0, 1);
        drive_frame(1);
        prev_end_low = 1'b1;

        // Randomized frames checked against the reference model.
        for (int f = 0; f < 60; f++) begin
            frm  = {};
            gap  = $urandom_range(1, 3);
            npre = $urandom_range(0, 17);
            npay = $urandom_range(0, 44);
            for (int i = 0; i < npre; i++) frm.push_back(4'($urandom_range(0, 15)));
            frm.push_back(SYNC_BYTE[7:4]);
            frm.push_back(SYNC_BYTE[3:0]);
            for (int i = 0; i < npay; i++) frm.push_back(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) != 0) begin
                frm.push_back(GUARD_NIBBLE);
                frm.push_back(GUARD_NIBBLE);
            end
            model_frame(gap);
            drive_frame(gap);
        end

        repeat (10) cyc(1'b0, 4'h0);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
